// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types, defaults and helpers for the round-robin mux arbiter
package mux_arb_pkg;

    localparam int MUX_ARB_MAX_N         = 16;
    localparam int MUX_ARB_DEF_N         = 13;
    localparam int MUX_ARB_DEF_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [MUX_ARB_MAX_N-1:0] onehot(input int idx, input int n);
        logic [MUX_ARB_MAX_N-1:0] v;
        v = '0;
        for (int i = 0; i < MUX_ARB_MAX_N; i++) begin
            if (i < n && i == idx) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester/downstream bundle; MUX_ARB_LOCK_EN adds the lock input
interface mux_rr_arbiter_if
    import mux_arb_pkg::*;
#(
    parameter int N     = MUX_ARB_DEF_N,
    parameter int SEL_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic [N-1:0]     data_in;
    logic             out_ready;
    logic             out_valid;
    logic             out_data;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     grant;
    logic             busy;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;

    modport master (input req, data_in, out_ready, lock,
                    output out_valid, out_data, sel, grant, busy);
    modport slave  (output req, data_in, out_ready, lock,
                    input out_valid, out_data, sel, grant, busy);
`else
    modport master (input req, data_in, out_ready,
                    output out_valid, out_data, sel, grant, busy);
    modport slave  (output req, data_in, out_ready,
                    input out_valid, out_data, sel, grant, busy);
`endif
endinterface

// File: rtl/mux_rr_pick.sv
// rtl/mux_rr_pick.sv - combinational round-robin finder: first set req after index last
module mux_rr_pick
#(
    parameter int N     = 13,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    // Walk from farthest to nearest so the nearest candidate after last wins.
    always_comb begin
        int j;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (req[j]) begin
                idx   = SEL_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin burst arbiter driving an N:1 bit-mux tree
// Optional burst lock when MUX_ARB_LOCK_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = MUX_ARB_DEF_N,
    parameter int MAX_BURST = MUX_ARB_DEF_MAX_BURST
) (
    input  logic                clk,
    input  logic                rst,
    mux_rr_arbiter_if.master    bus
);

    localparam int SEL_W = $clog2(N);
    localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int P     = 1 << SEL_W;
    localparam logic [BC_W-1:0] LIMIT = BC_W'(MAX_BURST - 1);

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel_q, sel_nx, last_q, last_nx;
    logic [N-1:0]     grant_q, grant_nx;
    logic [BC_W-1:0]  beat_q, beat_nx;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             valid, xfer, at_limit, hold_burst;

    mux_rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign valid    = (state == GRANT) && bus.req[sel_q];
    assign xfer     = valid && bus.out_ready;
    assign at_limit = (beat_q == LIMIT);
`ifdef MUX_ARB_LOCK_EN
    assign hold_burst = bus.lock;
`else
    assign hold_burst = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
            grant_q <= '0;
            beat_q  <= '0;
        end else begin
            state   <= state_nx;
            sel_q   <= sel_nx;
            last_q  <= last_nx;
            grant_q <= grant_nx;
            beat_q  <= beat_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        last_nx  = last_q;
        grant_nx = grant_q;
        beat_nx  = beat_q;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    sel_nx   = pick_idx;
                    last_nx  = pick_idx;
                    grant_nx = N'(onehot(int'(pick_idx), N));
                    beat_nx  = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    beat_nx  = '0;
                end else if (xfer) begin
                    // A locked burst parks the counter at the limit instead of releasing.
                    if (!at_limit) begin
                        beat_nx = beat_q + 1'b1;
                    end else if (!hold_burst) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        beat_nx  = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Binary tree of 2:1 muxes; level l consumes sel bit l-1, unused leaves tied low.
    for (genvar l = 0; l <= SEL_W; l++) begin : g_lvl
        logic [(P >> l)-1:0] v;
        if (l == 0) begin : g_leaf
            assign v = P'(bus.data_in);
        end else begin : g_node
            for (genvar k = 0; k < (P >> l); k++) begin : g_m
                assign v[k] = sel_q[l-1] ? g_lvl[l-1].v[2*k+1] : g_lvl[l-1].v[2*k];
            end
        end
    end

    assign bus.out_data  = g_lvl[SEL_W].v[0];
    assign bus.out_valid = valid;
    assign bus.busy      = (state == GRANT);
    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed and randomized checks of mux_rr_arbiter against a grant-level model
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int N  = 13;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.N(N)) bus ();

    mux_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Model: who owns the channel (-1 = nobody), beats moved in this grant, last winner.
    int owner, mbeats, mlast, msel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic lock_now();
`ifdef MUX_ARB_LOCK_EN
        return bus.lock;
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_reset();
        owner  = -1;
        mbeats = 0;
        mlast  = N - 1;
        msel   = 0;
    endtask

    task automatic mdl_step();
        if (rst) begin
            mdl_reset();
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (mlast + k) % N;
                if (bus.req[j]) begin
                    owner  = j;
                    msel   = j;
                    mlast  = j;
                    mbeats = 0;
                    break;
                end
            end
        end else if (!bus.req[owner]) begin
            owner = -1;
        end else if (bus.out_ready) begin
            mbeats++;
            if (mbeats >= MB && !lock_now()) owner = -1;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic         ev;
        eg = '0;
        if (owner >= 0) eg[owner] = 1'b1;
        ev = (owner >= 0) && bus.req[owner];
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("sel", 32'(bus.sel), 32'(msel));
        chk("busy", 32'(bus.busy), 32'(owner >= 0));
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        if (ev) chk("out_data", 32'(bus.out_data), 32'(bus.data_in[msel]));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_x, n_bad;
        rst           = 1'b1;
        bus.req       = '0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        bus.lock      = 1'b0;
`endif
        mdl_reset();
        #3;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        repeat (2) cycle();
        rst = 1'b0;

        // Sole requester 0: bursts of MB with one bubble, re-granted each time.
        bus.req       = 13'h0001;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.data_in = N'($urandom);
            cycle();
        end

        // Everyone requesting: full rotation with fixed data pattern.
        bus.req     = '1;
        bus.data_in = 13'h1555;
        repeat (N * (MB + 1) + 4) cycle();

        // Stall a grant to 5 with ready low.
        bus.req = 13'h0020;
        for (int i = 0; i < 20 && bus.grant != 13'h0020; i++) cycle();
        chk("reach_5", 32'(bus.grant), 32'h20);
        bus.out_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_sel", 32'(bus.sel), 32'd5);
        bus.out_ready = 1'b1;
        repeat (7) cycle();

        // Requester 3 withdraws mid-burst, 7 takes over.
        bus.req = 13'h0008;
        for (int i = 0; i < 20 && bus.grant != 13'h0008; i++) cycle();
        chk("reach_3", 32'(bus.grant), 32'h8);
        repeat (2) cycle();
        bus.req = 13'h0080;
        repeat (4) cycle();
        chk("took_7", 32'(bus.grant), 32'h80);

        // Async reset in the middle of a grant to 9.
        bus.req = 13'h0200;
        for (int i = 0; i < 20 && bus.grant != 13'h0200; i++) cycle();
        chk("reach_9", 32'(bus.grant), 32'h200);
        repeat (2) cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(bus.grant), 32'h0);
        chk("async_busy", 32'(bus.busy), 32'h0);
        chk("async_valid", 32'(bus.out_valid), 32'h0);
        mdl_reset();
        cycle();
        rst     = 1'b0;
        bus.req = '1;
        repeat (3) cycle();
        chk("post_rst_0", 32'(bus.grant), 32'h1);

`ifdef MUX_ARB_LOCK_EN
        // Locked burst on requester 2: ten beats under one grant.
        bus.req  = 13'h0004;
        bus.lock = 1'b1;
        for (int i = 0; i < 30 && bus.grant != 13'h0004; i++) cycle();
        chk("reach_2", 32'(bus.grant), 32'h4);
        n_x   = 0;
        n_bad = 0;
        for (int i = 0; i < 40 && n_x < 10; i++) begin
            if (bus.grant != 13'h0004) n_bad++;
            if (bus.out_valid && bus.out_ready) n_x++;
            cycle();
        end
        chk("lock_xfers", 32'(n_x), 32'd10);
        chk("lock_held", 32'(n_bad), 32'd0);
        chk("lock_still", 32'(bus.grant), 32'h4);
        bus.lock = 1'b0;
        repeat (4) cycle();
`else
        n_x   = 0;
        n_bad = 0;
`endif

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            bus.req       = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 9) == 0) bus.req = '0;
            bus.data_in   = N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
            bus.lock      = ($urandom_range(0, 2) == 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
